// File: rtl/seven_seg_display_unit.sv
// seven_seg_display_unit
// Display helper for the game top level:
//   - combinational hex nibble -> 7-segment decoder
//   - registered 8-bit binary -> two-digit decimal (value mod 100) segment driver
//   - power-on reset-delay generator for downstream PLL/VGA logic
// Segment encoding is {g,f,e,d,c,b,a}, active-low (0 = lit).
module seven_seg_display_unit #(
   parameter int             CNT_W      = 20,
   parameter logic [CNT_W-1:0] DELAY    = 20'hFFFFF,
   parameter bit             BLANK_TENS = 1'b0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] hex_in,
   output logic [6:0] hex_seg,
   input  logic [7:0] dec_in,
   output logic [6:0] dec_seg_ones,
   output logic [6:0] dec_seg_tens,
   output logic       rst_dly_done
);

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_ZERO  = 7'h40;

   // Nibble to segment pattern, shared by the hex and decimal paths.
   function automatic logic [6:0] f_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Hex path: pure decode, no reset, zero latency.
   assign hex_seg = f_seg(hex_in);

   // ---------------------------------------------------------------
   // Decimal path
   // ---------------------------------------------------------------
   logic [7:0] w_bcd;        // {tens, ones} BCD of dec_in % 100
   logic [6:0] w_tens_seg;
   logic [6:0] r_ones;
   logic [6:0] r_tens;

   // Double-dabble keeping only the tens/ones digits: the bit shifted out
   // of the tens digit would belong to the hundreds digit, so dropping it
   // yields the value mod 100 directly.
   always_comb begin
      w_bcd = 8'd0;
      for (int i = 7; i >= 0; i--) begin
         if (w_bcd[3:0] > 4'd4) w_bcd[3:0] = w_bcd[3:0] + 4'd3;
         if (w_bcd[7:4] > 4'd4) w_bcd[7:4] = w_bcd[7:4] + 4'd3;
         w_bcd = {w_bcd[6:0], dec_in[i]};
      end
   end

   // Tens digit optionally blanked when it would show a leading zero.
   assign w_tens_seg = (BLANK_TENS && (w_bcd[7:4] == 4'd0)) ? SEG_BLANK : f_seg(w_bcd[7:4]);

   // Capture both digits on the same edge so the pair never tears.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ones <= SEG_ZERO;
         r_tens <= BLANK_TENS ? SEG_BLANK : SEG_ZERO;
      end else begin
         r_ones <= f_seg(w_bcd[3:0]);
         r_tens <= w_tens_seg;
      end
   end

   assign dec_seg_ones = r_ones;
   assign dec_seg_tens = r_tens;

   // ---------------------------------------------------------------
   // Reset delay
   // ---------------------------------------------------------------
   // Power-up values give the same sequence as a reset pulse would.
   logic [CNT_W-1:0] r_cnt  = '0;
   logic             r_done = 1'b0;

   // Count up to DELAY and park there; done rises on the edge after the
   // counter reaches DELAY, i.e. the (DELAY+1)th edge after release.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else if (r_cnt != DELAY) begin
         r_cnt  <= r_cnt + CNT_W'(1);
         r_done <= 1'b0;
      end else begin
         r_cnt  <= r_cnt;
         r_done <= 1'b1;
      end
   end

   assign rst_dly_done = r_done;

endmodule

// File: tb/tb_seven_seg_display_unit.sv
// Self-checking bench for seven_seg_display_unit: table-driven vectors,
// randomized decimal stream against an arithmetic model, reset-delay sequences.
module tb_seven_seg_display_unit;

   logic       clock;
   logic       reset;
   logic [3:0] hex_in;
   logic [7:0] dec_in;
   logic [6:0] hex_seg,  dec_seg_ones,  dec_seg_tens;
   logic [6:0] hex_seg_b, dec_seg_ones_b, dec_seg_tens_b;
   logic       rst_dly_done, rst_dly_done_b;

   int n_checks = 0;
   int n_fail   = 0;

   seven_seg_display_unit #(.CNT_W(20), .DELAY(20'd5), .BLANK_TENS(1'b0)) u_dut (
      .clock        (clock),
      .reset        (reset),
      .hex_in       (hex_in),
      .hex_seg      (hex_seg),
      .dec_in       (dec_in),
      .dec_seg_ones (dec_seg_ones),
      .dec_seg_tens (dec_seg_tens),
      .rst_dly_done (rst_dly_done)
   );

   seven_seg_display_unit #(.CNT_W(20), .DELAY(20'd5), .BLANK_TENS(1'b1)) u_blk (
      .clock        (clock),
      .reset        (reset),
      .hex_in       (hex_in),
      .hex_seg      (hex_seg_b),
      .dec_in       (dec_in),
      .dec_seg_ones (dec_seg_ones_b),
      .dec_seg_tens (dec_seg_tens_b),
      .rst_dly_done (rst_dly_done_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference segment table, written straight from the code list.
   logic [6:0] seg_tab [16];

   function automatic logic [6:0] m_ones(input int v);
      return seg_tab[(v % 100) % 10];
   endfunction

   function automatic logic [6:0] m_tens(input int v, input bit blank);
      int t;
      t = (v % 100) / 10;
      if (blank && t == 0) return 7'h7F;
      return seg_tab[t];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [3:0] hex;
      logic [6:0] seg;
   } hex_vec_t;

   typedef struct {
      logic [7:0] dec;
      logic [6:0] tens;
      logic [6:0] ones;
   } dec_vec_t;

   hex_vec_t hvec [16];
   dec_vec_t dvec [10];

   // Release reset at a falling edge, then check done over the following edges.
   task automatic delay_run(input string tag, input int extra);
      @(negedge clock) reset = 1'b0;
      for (int e = 1; e <= 6 + extra; e++) begin
         @(posedge clock); #1;
         check({tag, "_done"}, {31'd0, rst_dly_done}, {31'd0, (e >= 6)});
         if (e <= 6) check({tag, "_done_b"}, {31'd0, rst_dly_done_b}, {31'd0, (e >= 6)});
      end
      $display("delay %s: %0d edges observed", tag, 6 + extra);
   endtask

   initial begin
      logic [7:0] prev;
      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      hvec = '{'{4'h0, 7'h40}, '{4'h1, 7'h79}, '{4'h2, 7'h24}, '{4'h3, 7'h30},
               '{4'h4, 7'h19}, '{4'h5, 7'h12}, '{4'h6, 7'h02}, '{4'h7, 7'h78},
               '{4'h8, 7'h00}, '{4'h9, 7'h10}, '{4'hA, 7'h08}, '{4'hB, 7'h03},
               '{4'hC, 7'h46}, '{4'hD, 7'h21}, '{4'hE, 7'h06}, '{4'hF, 7'h0E}};
      dvec = '{'{8'd0,   7'h40, 7'h40}, '{8'd7,   7'h40, 7'h78},
               '{8'd9,   7'h40, 7'h10}, '{8'd10,  7'h79, 7'h40},
               '{8'd29,  7'h24, 7'h10}, '{8'd30,  7'h30, 7'h40},
               '{8'd99,  7'h10, 7'h10}, '{8'd100, 7'h40, 7'h40},
               '{8'd130, 7'h30, 7'h40}, '{8'd255, 7'h12, 7'h12}};

      reset  = 1'b1;
      hex_in = 4'h0;
      dec_in = 8'd37;
      #1;
      // Reset state
      check("rst_ones",   {25'd0, dec_seg_ones},   32'h40);
      check("rst_tens",   {25'd0, dec_seg_tens},   32'h40);
      check("rst_ones_b", {25'd0, dec_seg_ones_b}, 32'h40);
      check("rst_tens_b", {25'd0, dec_seg_tens_b}, 32'h7F);
      check("rst_done",   {31'd0, rst_dly_done},   32'd0);

      // Hex decode while reset is high
      for (int i = 0; i < 16; i++) begin
         hex_in = hvec[i].hex; #1;
         check("hex_in_reset", {25'd0, hex_seg}, {25'd0, hvec[i].seg});
      end
      repeat (2) @(posedge clock);
      #1;
      check("rst_hold_ones", {25'd0, dec_seg_ones}, 32'h40);

      @(negedge clock) reset = 1'b0;

      // Hex sweep, same cycle
      for (int i = 0; i < 16; i++) begin
         hex_in = hvec[i].hex; #1;
         check("hex", {25'd0, hex_seg}, {25'd0, hvec[i].seg});
         check("hex_b", {25'd0, hex_seg_b}, {25'd0, hvec[i].seg});
         $display("hex %h -> %h", hvec[i].hex, hex_seg);
      end

      // Decimal vectors, one-edge latency
      for (int i = 0; i < 10; i++) begin
         @(negedge clock) dec_in = dvec[i].dec;
         @(posedge clock); #1;
         check("dec_tens", {25'd0, dec_seg_tens}, {25'd0, dvec[i].tens});
         check("dec_ones", {25'd0, dec_seg_ones}, {25'd0, dvec[i].ones});
         check("dec_tens_b", {25'd0, dec_seg_tens_b}, {25'd0, m_tens(int'(dvec[i].dec), 1'b1)});
         check("dec_ones_b", {25'd0, dec_seg_ones_b}, {25'd0, m_ones(int'(dvec[i].dec))});
         $display("dec %0d -> tens %h ones %h", dvec[i].dec, dec_seg_tens, dec_seg_ones);
      end

      // Randomized stream: new value every cycle, outputs follow one edge later
      prev = dec_in;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock) dec_in = 8'($urandom_range(0, 255));
         #1;
         check("stream_hold_ones", {25'd0, dec_seg_ones}, {25'd0, m_ones(int'(prev))});
         @(posedge clock); #1;
         check("stream_tens", {25'd0, dec_seg_tens}, {25'd0, m_tens(int'(dec_in), 1'b0)});
         check("stream_ones", {25'd0, dec_seg_ones}, {25'd0, m_ones(int'(dec_in))});
         check("stream_tens_b", {25'd0, dec_seg_tens_b}, {25'd0, m_tens(int'(dec_in), 1'b1)});
         prev = dec_in;
      end
      $display("stream: 60 random values applied");

      // Reset mid-stream, away from any clock edge
      @(negedge clock) dec_in = 8'd87;
      @(posedge clock); #2;
      reset = 1'b1; #1;
      check("midrst_ones",   {25'd0, dec_seg_ones},   32'h40);
      check("midrst_tens",   {25'd0, dec_seg_tens},   32'h40);
      check("midrst_tens_b", {25'd0, dec_seg_tens_b}, 32'h7F);
      check("midrst_done",   {31'd0, rst_dly_done},   32'd0);

      // Reset delay: low for 5 edges, high on edge 6, stays high 100 more
      delay_run("dly_first", 100);

      // Pulse reset after done: drops at once, rises 6 edges after release
      @(negedge clock) reset = 1'b1; #1;
      check("pulse_after_done", {31'd0, rst_dly_done}, 32'd0);
      delay_run("dly_after_done", 2);

      // Pulse reset at edge 3 of a count
      @(negedge clock) reset = 1'b1;
      @(negedge clock) reset = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         @(posedge clock); #1;
         check("mid_count_done", {31'd0, rst_dly_done}, 32'd0);
      end
      #1 reset = 1'b1; #1;
      check("pulse_mid_count", {31'd0, rst_dly_done}, 32'd0);
      @(posedge clock);
      delay_run("dly_mid_count", 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
